// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Purpose : Bundles the fetch sequencer's control, LUT-load and status signals.
// Signals : Start, Halt, Jump, BranchEn, BranchAccept, BranchIdx  (to sequencer)
//           LutWrEn, LutWrIdx, LutWrData                          (to sequencer)
//           PC, Running, Done, CycleCount                         (from sequencer)
// Modports: master drives the controls and reads the status; slave is the
//           fetch_unit side.
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int unsigned PC_W      = 10,
    parameter int unsigned LUT_IDX_W = 5,
    parameter int unsigned CNT_W     = 16
);
    logic                 Start;
    logic                 Halt;
    logic                 Jump;
    logic                 BranchEn;
    logic                 BranchAccept;
    logic [LUT_IDX_W-1:0] BranchIdx;
    logic                 LutWrEn;
    logic [LUT_IDX_W-1:0] LutWrIdx;
    logic [PC_W-1:0]      LutWrData;
    logic [PC_W-1:0]      PC;
    logic                 Running;
    logic                 Done;
    logic [CNT_W-1:0]     CycleCount;

    modport master (
        output Start, Halt, Jump, BranchEn, BranchAccept, BranchIdx,
        output LutWrEn, LutWrIdx, LutWrData,
        input  PC, Running, Done, CycleCount
    );

    modport slave (
        input  Start, Halt, Jump, BranchEn, BranchAccept, BranchIdx,
        input  LutWrEn, LutWrIdx, LutWrData,
        output PC, Running, Done, CycleCount
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Purpose : Program counter and fetch sequencer. Sequences IDLE -> RUN -> HALTED,
//           steps the instruction ROM address, takes jumps/accepted branches
//           through a loadable branch-target LUT and counts RUN cycles.
// Ports   : Clk      - system clock, rising edge
//           Reset_n  - asynchronous active-low reset (clears state and LUT)
//           bus      - fetch_unit_if.slave: controls in, PC/status out
// Options : FETCH_BRANCH_REL_EN - when defined, LUT entries are two's-complement
//           offsets added to the current PC; otherwise they are absolute targets.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned LUT_IDX_W  = 5,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    fetch_unit_if.slave   bus
);

    localparam int unsigned LutDepth = 1 << LUT_IDX_W;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalted
    } state_e;

    state_e            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [CNT_W-1:0]  r_cnt;
    logic [PC_W-1:0]   r_lut [LutDepth];

    state_e            w_state_next;
    logic [PC_W-1:0]   w_pc_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [PC_W-1:0]   w_lut_rd;
    logic [PC_W-1:0]   w_target;
    logic              w_taken;

    // Combinational read sees the pre-edge entry, so a same-cycle write to the
    // branched-to index only affects later branches.
    assign w_lut_rd = r_lut[bus.BranchIdx];
    assign w_taken  = bus.Jump | (bus.BranchEn & bus.BranchAccept);

`ifdef FETCH_BRANCH_REL_EN
    assign w_target = r_pc + w_lut_rd;
`else
    assign w_target = w_lut_rd;
`endif

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            StIdle, StHalted: begin
                if (bus.Start) begin
                    w_state_next = StRun;
                    w_pc_next    = PC_W'(START_ADDR);
                    w_cnt_next   = '0;
                end
            end
            StRun: begin
                // The halting cycle is still a RUN cycle, so it is counted.
                if (r_cnt != {CNT_W{1'b1}}) begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
                if (bus.Halt) begin
                    w_state_next = StHalted;
                end else if (w_taken) begin
                    w_pc_next = w_target;
                end else begin
                    w_pc_next = r_pc + PC_W'(1);
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= StIdle;
            r_pc    <= PC_W'(START_ADDR);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < LutDepth; i++) begin
                r_lut[i] <= '0;
            end
        end else if (bus.LutWrEn) begin
            r_lut[bus.LutWrIdx] <= bus.LutWrData;
        end
    end

    assign bus.PC         = r_pc;
    assign bus.Running    = (r_state == StRun);
    assign bus.Done       = (r_state == StHalted);
    assign bus.CycleCount = r_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Purpose : Self-checking bench for fetch_unit. Directed scenarios plus random
//           control traffic, all compared against a cycle-level behavioural
//           model. CNT_W is reduced so counter saturation is reachable.
// Options : FETCH_BRANCH_REL_EN selects relative-branch expectations.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int unsigned PC_W       = 10;
    localparam int unsigned LUT_IDX_W  = 5;
    localparam int unsigned START_ADDR = 0;
    localparam int unsigned CNT_W      = 4;
    localparam int          LutDepth   = 1 << LUT_IDX_W;
    localparam int          PcMask     = (1 << PC_W) - 1;
    localparam int          CntMax     = (1 << CNT_W) - 1;

    logic Clk;
    logic Reset_n;

    fetch_unit_if #(
        .PC_W      (PC_W),
        .LUT_IDX_W (LUT_IDX_W),
        .CNT_W     (CNT_W)
    ) bus ();

    fetch_unit #(
        .PC_W       (PC_W),
        .LUT_IDX_W  (LUT_IDX_W),
        .START_ADDR (START_ADDR),
        .CNT_W      (CNT_W)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: plain integers for the PC, count and LUT contents.
    int m_pc;
    int m_cnt;
    bit m_run;
    bit m_done;
    int m_lut [LutDepth];

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = START_ADDR;
        m_cnt  = 0;
        m_run  = 1'b0;
        m_done = 1'b0;
        for (int i = 0; i < LutDepth; i++) m_lut[i] = 0;
    endtask

    task automatic model_step(input bit st, input bit ha, input bit ju, input bit be,
                              input bit ba, input int idx, input bit we,
                              input int widx, input int wd);
        if (!m_run) begin
            if (st) begin
                m_run  = 1'b1;
                m_done = 1'b0;
                m_pc   = START_ADDR;
                m_cnt  = 0;
            end
        end else begin
            if (m_cnt < CntMax) m_cnt = m_cnt + 1;
            if (ha) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end else if (ju || (be && ba)) begin
`ifdef FETCH_BRANCH_REL_EN
                m_pc = (m_pc + m_lut[idx]) & PcMask;
`else
                m_pc = m_lut[idx];
`endif
            end else begin
                m_pc = (m_pc + 1) & PcMask;
            end
        end
        // Write lands after the branch has used the old entry.
        if (we) m_lut[widx] = wd & PcMask;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".pc"},      32'(bus.PC),         32'(m_pc));
        check_eq({tag, ".running"}, 32'(bus.Running),    32'(m_run));
        check_eq({tag, ".done"},    32'(bus.Done),       32'(m_done));
        check_eq({tag, ".cnt"},     32'(bus.CycleCount), 32'(m_cnt));
    endtask

    task automatic cyc(input string tag, input bit st, input bit ha, input bit ju,
                       input bit be, input bit ba, input int idx, input bit we,
                       input int widx, input int wd);
        bus.Start        = st;
        bus.Halt         = ha;
        bus.Jump         = ju;
        bus.BranchEn     = be;
        bus.BranchAccept = ba;
        bus.BranchIdx    = LUT_IDX_W'(idx);
        bus.LutWrEn      = we;
        bus.LutWrIdx     = LUT_IDX_W'(widx);
        bus.LutWrData    = PC_W'(wd);
        model_step(st, ha, ju, be, ba, idx, we, widx, wd);
        @(posedge Clk);
        #1;
        check_state(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lut_wr(input int widx, input int wd);
        cyc("lutwr", 0, 0, 0, 0, 0, 0, 1, widx, wd);
    endtask

    initial begin
        Reset_n          = 1'b0;
        bus.Start        = 1'b0;
        bus.Halt         = 1'b0;
        bus.Jump         = 1'b0;
        bus.BranchEn     = 1'b0;
        bus.BranchAccept = 1'b0;
        bus.BranchIdx    = '0;
        bus.LutWrEn      = 1'b0;
        bus.LutWrIdx     = '0;
        bus.LutWrData    = '0;
        model_reset();
        #2;
        check_state("reset");
        #5 Reset_n = 1'b1;

        // Controls other than Start are ignored in IDLE.
        cyc("idle_ign", 0, 1, 1, 1, 1, 3, 0, 0, 0);
        cyc("start", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("step", 5);
        check_eq("tp1.pc", 32'(bus.PC), 32'd5);
        check_eq("tp1.cnt", 32'(bus.CycleCount), 32'd5);

        lut_wr(3, 'h040);
        cyc("start_in_run", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("br_taken", 0, 0, 0, 1, 1, 3, 0, 0, 0);
`ifndef FETCH_BRANCH_REL_EN
        check_eq("tp2.pc", 32'(bus.PC), 32'h040);
`endif
        cyc("br_not_acc", 0, 0, 0, 1, 0, 3, 0, 0, 0);
        cyc("jump", 0, 0, 1, 0, 0, 3, 0, 0, 0);
        cyc("acc_no_en", 0, 0, 0, 0, 1, 3, 0, 0, 0);

        lut_wr(2, 'h012);
        cyc("jump12", 0, 0, 1, 0, 0, 2, 0, 0, 0);
        cyc("halt_jump", 0, 1, 1, 0, 0, 3, 0, 0, 0);
`ifndef FETCH_BRANCH_REL_EN
        check_eq("tp4.pc", 32'(bus.PC), 32'h012);
`endif
        check_eq("tp4.done", 32'(bus.Done), 32'd1);
        idle("halted_hold", 3);
        cyc("restart", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("tp4.restart_pc", 32'(bus.PC), 32'(START_ADDR));
        check_eq("tp4.restart_done", 32'(bus.Done), 32'd0);

        lut_wr(4, 'h3FF);
        cyc("jump3ff", 0, 0, 1, 0, 0, 4, 0, 0, 0);
        cyc("wrap", 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifndef FETCH_BRANCH_REL_EN
        check_eq("tp5.wrap_pc", 32'(bus.PC), 32'h000);
`endif

        lut_wr(5, 'h100);
        cyc("wr_same_idx", 0, 0, 1, 0, 0, 5, 1, 5, 'h200);
`ifndef FETCH_BRANCH_REL_EN
        check_eq("tp5.old_entry", 32'(bus.PC), 32'h100);
`endif
        cyc("new_entry", 0, 0, 1, 0, 0, 5, 0, 0, 0);

        idle("sat", 20);
        check_eq("cnt_sat", 32'(bus.CycleCount), 32'(CntMax));

        // Relative build: offset -2 from 0x010 lands on 0x00E.
        cyc("halt_pre_rel", 0, 1, 0, 0, 0, 0, 1, 1, 'h3FE);
        cyc("start_rel", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("to_10", 16);
        cyc("br_rel", 0, 0, 0, 1, 1, 1, 0, 0, 0);
`ifdef FETCH_BRANCH_REL_EN
        check_eq("tp6.rel_pc", 32'(bus.PC), 32'h00E);
`endif

        for (int i = 0; i < 500; i++) begin
            cyc("rand",
                ($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 9) == 0),  ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 1) == 0),  int'($urandom_range(0, 7)),
                ($urandom_range(0, 4) == 0),  int'($urandom_range(0, 7)),
                int'($urandom_range(0, PcMask)));
        end

        // Asynchronous reset mid-RUN, away from any rising edge.
        cyc("pre_rst_start", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        lut_wr(3, 'h155);
        @(negedge Clk);
        #1 Reset_n = 1'b0;
        model_reset();
        #1;
        check_state("async_rst");
        check_eq("async_rst.pc", 32'(bus.PC), 32'(START_ADDR));
        #1 Reset_n = 1'b1;
        cyc("post_rst_start", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("lut_cleared", 0, 0, 1, 0, 0, 3, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
